// File: rtl/tt_proj_mux_ctrl.sv
// Project-slot owner for the shared iw/ow buses: one-hot enable plus the
// drain -> clocked-reset -> run sequence on every switch-over.
module tt_proj_mux_ctrl #(
    parameter int N_PROJ     = 8,
    parameter int ADDR_W     = 4,
    parameter int DRAIN_CYC  = 4,
    parameter int RST_PULSES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sel_valid,
    input  logic [ADDR_W-1:0]      sel_addr,
    output logic                   sel_ready,
    output logic                   busy,
    output logic [ADDR_W-1:0]      cur_addr,
    input  logic                   pad_clk,
    input  logic                   pad_rst_n,
    input  logic [7:0]             pad_ui_in,
    input  logic [7:0]             pad_uio_in,
    output logic [N_PROJ-1:0]      proj_ena,
    output logic [17:0]            iw,
    input  logic [24*N_PROJ-1:0]   ow_bus,
    output logic [23:0]            ow_sel
);

    localparam int CNT_MAX = (DRAIN_CYC > 2*RST_PULSES) ? DRAIN_CYC : 2*RST_PULSES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0]  RESET_LOAD = CNT_W'(2*RST_PULSES - 1);
    localparam logic [ADDR_W:0]   N_PROJ_EXT = (ADDR_W+1)'(N_PROJ);
    localparam logic [ADDR_W-1:0] ADDR_OFF   = '1;

    typedef enum logic [1:0] {S_OFF, S_DRAIN, S_RESET, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              clk_bit_q, clk_bit_d;

    logic [N_PROJ-1:0] cur_hit;
    logic [N_PROJ-1:0] tgt_hit;
    logic [23:0]       ow_slot [N_PROJ];
    logic [23:0]       run_ow;
    logic              accept;
    logic              sel_in_range;
    logic              tgt_in_range;

    // Slot decoders compare against the slot index, so out-of-range
    // addresses simply decode to no slot at all.
    for (genvar gi = 0; gi < N_PROJ; gi++) begin : g_slot
        localparam logic [ADDR_W-1:0] SLOT = ADDR_W'(gi);
        assign cur_hit[gi] = (cur_addr_q == SLOT);
        assign tgt_hit[gi] = (target_q == SLOT);
        assign ow_slot[gi] = ow_bus[24*gi +: 24];
    end

    assign accept       = sel_valid && ((state_q == S_OFF) || (state_q == S_RUN));
    assign sel_in_range = ({1'b0, sel_addr} < N_PROJ_EXT);
    assign tgt_in_range = ({1'b0, target_q} < N_PROJ_EXT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OFF;
            cnt_q      <= '0;
            target_q   <= ADDR_OFF;
            cur_addr_q <= ADDR_OFF;
            clk_bit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            cur_addr_q <= cur_addr_d;
            clk_bit_q  <= clk_bit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        cur_addr_d = cur_addr_q;
        clk_bit_d  = 1'b0;
        unique case (state_q)
            S_OFF: begin
                if (accept && sel_in_range) begin
                    target_d = sel_addr;
                    cnt_d    = DRAIN_LOAD;
                    state_d  = S_DRAIN;
                end
            end
            S_RUN: begin
                // Same address is accepted too: it forces a full re-reset.
                if (accept) begin
                    target_d = sel_addr;
                    cnt_d    = DRAIN_LOAD;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    if (tgt_in_range) begin
                        state_d = S_RESET;
                        cnt_d   = RESET_LOAD;
                    end else begin
                        state_d    = S_OFF;
                        cur_addr_d = ADDR_OFF;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESET: begin
                // Even cycle count: the clock bit falls back to 0 on exit.
                clk_bit_d = ~clk_bit_q;
                if (cnt_q == '0) begin
                    state_d    = S_RUN;
                    cur_addr_d = target_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    always_comb begin
        run_ow = '0;
        for (int i = 0; i < N_PROJ; i++) begin
            if (cur_hit[i]) run_ow = ow_slot[i];
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        busy      = 1'b0;
        proj_ena  = '0;
        iw        = '0;
        ow_sel    = '0;
        cur_addr  = cur_addr_q;
        unique case (state_q)
            S_OFF: sel_ready = 1'b1;
            S_DRAIN: busy = 1'b1;
            S_RESET: begin
                busy     = 1'b1;
                proj_ena = tgt_hit;
                iw       = {16'h0000, 1'b0, clk_bit_q};
            end
            S_RUN: begin
                sel_ready = 1'b1;
                proj_ena  = cur_hit;
                iw        = {pad_uio_in, pad_ui_in, pad_rst_n, pad_clk};
                ow_sel    = run_ow;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
// Bench for tt_proj_mux_ctrl: per-cycle expectations queued by the stimulus
// and compared one cycle after each clock edge.
module tb_tt_proj_mux_ctrl;

    localparam int N_PROJ     = 8;
    localparam int ADDR_W     = 4;
    localparam int DRAIN_CYC  = 4;
    localparam int RST_PULSES = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sel_valid;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 sel_ready;
    logic                 busy;
    logic [ADDR_W-1:0]    cur_addr;
    logic                 pad_clk;
    logic                 pad_rst_n;
    logic [7:0]           pad_ui_in;
    logic [7:0]           pad_uio_in;
    logic [N_PROJ-1:0]    proj_ena;
    logic [17:0]          iw;
    logic [24*N_PROJ-1:0] ow_bus;
    logic [23:0]          ow_sel;

    tt_proj_mux_ctrl #(
        .N_PROJ(N_PROJ), .ADDR_W(ADDR_W), .DRAIN_CYC(DRAIN_CYC), .RST_PULSES(RST_PULSES)
    ) dut (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_addr(sel_addr),
        .sel_ready(sel_ready), .busy(busy), .cur_addr(cur_addr),
        .pad_clk(pad_clk), .pad_rst_n(pad_rst_n), .pad_ui_in(pad_ui_in),
        .pad_uio_in(pad_uio_in), .proj_ena(proj_ena), .iw(iw),
        .ow_bus(ow_bus), .ow_sel(ow_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ena;
        logic [17:0] iw;
        logic [23:0] ow;
        logic        ready;
        logic        busy;
        logic [3:0]  cur;
    } exp_t;

    typedef struct {
        logic        pclk;
        logic        prst_n;
        logic [7:0]  ui;
        logic [7:0]  uio;
        logic [23:0] ow3;
        logic [17:0] exp_iw;
        logic [23:0] exp_ow;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push_exp(input logic [7:0] ena, input logic [17:0] iwv, input logic [23:0] ow,
                            input logic rdy, input logic bsy, input logic [3:0] cur);
        exp_t e;
        e.ena = ena; e.iw = iwv; e.ow = ow; e.ready = rdy; e.busy = bsy; e.cur = cur;
        sb_q.push_back(e);
    endtask

    task automatic push_off();
        push_exp(8'h00, 18'h0, 24'h0, 1'b1, 1'b0, 4'hF);
    endtask

    // Drive request inputs, clock once, compare against the oldest expectation.
    task automatic step(input logic v, input logic [3:0] a, input string tag);
        exp_t e;
        sel_valid = v;
        sel_addr  = a;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no expectation queued, got ena=%h cur=%h", tag, proj_ena, cur_addr);
        end else begin
            e = sb_q.pop_front();
            if (proj_ena !== e.ena || iw !== e.iw || ow_sel !== e.ow ||
                sel_ready !== e.ready || busy !== e.busy || cur_addr !== e.cur) begin
                n_bad++;
                $display("FAIL %s: got ena=%h iw=%h ow=%h rdy=%b busy=%b cur=%h, need ena=%h iw=%h ow=%h rdy=%b busy=%b cur=%h",
                         tag, proj_ena, iw, ow_sel, sel_ready, busy, cur_addr,
                         e.ena, e.iw, e.ow, e.ready, e.busy, e.cur);
            end
        end
    endtask

    function automatic logic [17:0] run_iw();
        return {pad_uio_in, pad_ui_in, pad_rst_n, pad_clk};
    endfunction

    task automatic fill_ow_bus();
        for (int i = 0; i < N_PROJ; i++) ow_bus[24*i +: 24] = 24'($urandom) | 24'h1;
    endtask

    // Full switch-over: first step carries the request, the rest drive (hv, ha).
    task automatic sel_seq(input logic [3:0] addr, input logic [3:0] old_cur,
                           input logic hv, input logic [3:0] ha);
        logic [7:0] oh;
        oh = (addr < 4'(N_PROJ)) ? (8'h01 << addr) : 8'h00;
        $display("select addr=%0d from cur=%0h hold_valid=%b", addr, old_cur, hv);
        for (int i = 0; i < DRAIN_CYC; i++) begin
            push_exp(8'h00, 18'h0, 24'h0, 1'b0, 1'b1, old_cur);
            if (i == 0) step(1'b1, addr, "drain");
            else        step(hv, ha, "drain");
        end
        if (addr >= 4'(N_PROJ)) begin
            push_off();
            step(hv, ha, "to_off");
        end else begin
            for (int i = 0; i < 2*RST_PULSES; i++) begin
                push_exp(oh, {16'h0000, 1'b0, 1'(i % 2)}, 24'h0, 1'b0, 1'b1, old_cur);
                step(hv, ha, "reset_phase");
            end
            push_exp(oh, run_iw(), ow_bus[24*addr +: 24], 1'b1, 1'b0, addr);
            step(hv, ha, "run_entry");
        end
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 8'hA5, 8'h00, 24'h123456, 18'h00297, 24'h123456};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 8'hFF, 24'hABCDEF, 18'h3FC00, 24'hABCDEF};
        vecs[2] = '{1'b1, 1'b0, 8'h3C, 8'h81, 24'h000001, 18'h204F1, 24'h000001};
        vecs[3] = '{1'b0, 1'b1, 8'hFF, 8'h5A, 24'hFFFFFF, 18'h16BFE, 24'hFFFFFF};

        rst = 1'b1; sel_valid = 1'b0; sel_addr = '0;
        pad_clk = 1'b1; pad_rst_n = 1'b1; pad_ui_in = 8'hA5; pad_uio_in = 8'h3C;
        fill_ow_bus();

        // Reset state, then idle OFF and an out-of-range request that must be ignored.
        push_off(); step(1'b0, 4'd0, "reset_0");
        push_off(); step(1'b0, 4'd0, "reset_1");
        rst = 1'b0;
        push_off(); step(1'b0, 4'd0, "off_idle");
        push_off(); step(1'b1, 4'd12, "off_bad_addr");

        sel_seq(4'd3, 4'hF, 1'b0, 4'd0);

        // Data path in RUN slot 3; the other slots carry fresh junk each row.
        foreach (vecs[r]) begin
            fill_ow_bus();
            pad_clk = vecs[r].pclk; pad_rst_n = vecs[r].prst_n;
            pad_ui_in = vecs[r].ui; pad_uio_in = vecs[r].uio;
            ow_bus[24*3 +: 24] = vecs[r].ow3;
            push_exp(8'h08, vecs[r].exp_iw, vecs[r].exp_ow, 1'b1, 1'b0, 4'd3);
            $display("run vector %0d ui=%h uio=%h ow3=%h", r, vecs[r].ui, vecs[r].uio, vecs[r].ow3);
            step(1'b0, 4'd0, "run_vec");
        end
        pad_clk = 1'b1; pad_rst_n = 1'b1; pad_ui_in = 8'hC3; pad_uio_in = 8'h7E;
        fill_ow_bus();

        // 3 -> 5 while a request for 2 is held through the busy window,
        // then 2 is accepted on the first RUN cycle and held again (same-addr replay).
        sel_seq(4'd5, 4'd3, 1'b1, 4'd2);
        sel_seq(4'd2, 4'd5, 1'b1, 4'd2);
        sel_seq(4'd2, 4'd2, 1'b0, 4'd0);

        // Out-of-range address from RUN turns everything off.
        sel_seq(4'd12, 4'd2, 1'b0, 4'd0);

        // Abort mid-RESET with rst.
        $display("select addr=6 from cur=f, rst during reset phase");
        for (int i = 0; i < DRAIN_CYC; i++) begin
            push_exp(8'h00, 18'h0, 24'h0, 1'b0, 1'b1, 4'hF);
            step(i == 0, 4'd6, "abort_drain");
        end
        for (int i = 0; i < 3; i++) begin
            push_exp(8'h40, {16'h0000, 1'b0, 1'(i % 2)}, 24'h0, 1'b0, 1'b1, 4'hF);
            step(1'b0, 4'd0, "abort_reset_phase");
        end
        rst = 1'b1;
        push_off(); step(1'b0, 4'd0, "rst_abort");
        rst = 1'b0;
        push_off(); step(1'b0, 4'd0, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
